// File: rtl/ir_cmd_decoder.sv
// ir_cmd_decoder: turns raw NEC words into game commands.
// Each new key is decoded once. ENTER/MENU become one-cycle pulses.
// Directions go through a 2-deep queue that is drained one entry per game tick.
// Redundant turns and 180-degree reversals are rejected against the queue tail.
module ir_cmd_decoder #(
   parameter logic [31:0] UP    = 32'h20DF6A95,
   parameter logic [31:0] DOWN  = 32'h20DFEA15,
   parameter logic [31:0] LEFT  = 32'h20DF1AE5,
   parameter logic [31:0] RIGHT = 32'h20DF9A65,
   parameter logic [31:0] ENTER = 32'h20DF5AA5,
   parameter logic [31:0] MENU  = 32'h20DFC23D
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [31:0] word,
   input  logic        word_stb,
   input  logic        game_tick,
   input  logic        restart,
   output logic [1:0]  dir,
   output logic        dir_changed,
   output logic        enter_pulse,
   output logic        menu_pulse,
   output logic [1:0]  q_count,
   output logic [7:0]  drop_count
);

   logic [31:0] word_q;
   logic [1:0]  q0, q1;          // q0 = head (next to commit), q1 = second entry
   logic [1:0]  q0_n, q1_n, cnt_n;
   logic        new_key, is_dir;
   logic [1:0]  d_code, tail;
   logic        pop, rej, full_drop, push, drop;

   // A held word is one event; word_stb lets a repeated key count again.
   assign new_key = (word != word_q) || word_stb;

   // Map the incoming word to a direction code, if it is one.
   always_comb begin
      is_dir = 1'b1;
      d_code = 2'b00;
      if (word == UP)         d_code = 2'b00;
      else if (word == DOWN)  d_code = 2'b01;
      else if (word == LEFT)  d_code = 2'b10;
      else if (word == RIGHT) d_code = 2'b11;
      else                    is_dir = 1'b0;
   end

   // The tail is sampled before any same-cycle pop, so a push with one entry
   // queued is compared against the entry currently being committed.
   assign tail      = (q_count == 2'd0) ? dir : ((q_count == 2'd1) ? q0 : q1);
   assign pop       = game_tick && (q_count != 2'd0);
   assign rej       = (d_code == tail) || (d_code == (tail ^ 2'b01));
   assign full_drop = (q_count == 2'd2) && !pop;
   assign push      = new_key && is_dir && !rej && !full_drop;
   assign drop      = new_key && is_dir && (rej || full_drop);

   // Next queue contents from the push/pop combination.
   always_comb begin
      q0_n  = q0;
      q1_n  = q1;
      cnt_n = q_count;
      case ({push, pop})
         2'b10: begin
            if (q_count == 2'd0) q0_n = d_code;
            else                 q1_n = d_code;
            cnt_n = q_count + 2'd1;
         end
         2'b01: begin
            q0_n  = q1;
            cnt_n = q_count - 2'd1;
         end
         2'b11: begin
            if (q_count == 2'd1) begin
               q0_n = d_code;
            end else begin
               q0_n = q1;
               q1_n = d_code;
            end
         end
         default: ;
      endcase
   end

   // Registered state and outputs; restart overrides queue actions but not key pulses.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         word_q      <= 32'd0;
         q0          <= 2'b00;
         q1          <= 2'b00;
         q_count     <= 2'd0;
         dir         <= 2'b11;
         dir_changed <= 1'b0;
         enter_pulse <= 1'b0;
         menu_pulse  <= 1'b0;
         drop_count  <= 8'd0;
      end else begin
         if (new_key) word_q <= word;
         enter_pulse <= new_key && (word == ENTER);
         menu_pulse  <= new_key && (word == MENU);
         if (restart) begin
            q_count     <= 2'd0;
            dir         <= 2'b11;
            dir_changed <= 1'b0;
         end else begin
            q0          <= q0_n;
            q1          <= q1_n;
            q_count     <= cnt_n;
            dir_changed <= pop;
            if (pop) dir <= q0;
            if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// tb_ir_cmd_decoder: directed steps from the feature list followed by a
// randomized run, all compared against a queue-based reference model.
module tb_ir_cmd_decoder;

   localparam logic [31:0] C_UP    = 32'h20DF6A95;
   localparam logic [31:0] C_DOWN  = 32'h20DFEA15;
   localparam logic [31:0] C_LEFT  = 32'h20DF1AE5;
   localparam logic [31:0] C_RIGHT = 32'h20DF9A65;
   localparam logic [31:0] C_ENTER = 32'h20DF5AA5;
   localparam logic [31:0] C_MENU  = 32'h20DFC23D;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] word = 32'd0;
   logic        word_stb = 1'b0, game_tick = 1'b0, restart = 1'b0;
   logic [1:0]  dir, q_count;
   logic        dir_changed, enter_pulse, menu_pulse;
   logic [7:0]  drop_count;

   ir_cmd_decoder dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .word(word), .word_stb(word_stb),
      .game_tick(game_tick), .restart(restart), .dir(dir), .dir_changed(dir_changed),
      .enter_pulse(enter_pulse), .menu_pulse(menu_pulse), .q_count(q_count),
      .drop_count(drop_count)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int passed = 0;

   // reference model state
   logic [31:0] m_word_q;
   int          m_dir, m_drop;
   int          mq[$];
   bit          m_changed, m_enter, m_menu;
   int          enter_seen, menu_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int dir_of(input logic [31:0] w);
      if (w == C_UP)    return 0;
      if (w == C_DOWN)  return 1;
      if (w == C_LEFT)  return 2;
      if (w == C_RIGHT) return 3;
      return -1;
   endfunction

   // One clock: apply inputs, advance the model by the behavioural rules, compare.
   task automatic step(input logic [31:0] w, input bit stb, input bit tick,
                       input bit rs, input bit rst);
      bit nk, popping;
      int d, tl;
      word = w; word_stb = stb; game_tick = tick; restart = rs; reset = rst;
      @(posedge CLOCK_50);
      if (rst) begin
         m_word_q = 0; m_dir = 3; m_drop = 0; mq.delete();
         m_changed = 0; m_enter = 0; m_menu = 0;
      end else begin
         nk = (w != m_word_q) || stb;
         if (nk) m_word_q = w;
         m_enter = nk && (w == C_ENTER);
         m_menu  = nk && (w == C_MENU);
         m_changed = 0;
         if (rs) begin
            mq.delete();
            m_dir = 3;
         end else begin
            tl = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
            popping = tick && (mq.size() > 0);
            d = dir_of(w);
            if (popping) begin
               m_dir = mq.pop_front();
               m_changed = 1;
            end
            if (nk && d >= 0) begin
               if (d == tl || d == (tl ^ 1) || (mq.size() >= 2))
                  m_drop = (m_drop < 255) ? m_drop + 1 : 255;
               else
                  mq.push_back(d);
            end
         end
      end
      #1;
      chk("dir", dir, m_dir);
      chk("dir_changed", dir_changed, m_changed);
      chk("enter_pulse", enter_pulse, m_enter);
      chk("menu_pulse", menu_pulse, m_menu);
      chk("q_count", q_count, mq.size());
      chk("drop_count", drop_count, m_drop);
      if (enter_pulse) enter_seen++;
      if (menu_pulse) menu_seen++;
   endtask

   logic [31:0] pool [8];
   logic [31:0] rw;

   initial begin
      pool[0] = C_UP; pool[1] = C_DOWN; pool[2] = C_LEFT; pool[3] = C_RIGHT;
      pool[4] = C_ENTER; pool[5] = C_MENU; pool[6] = 32'h20DF0000; pool[7] = 32'h0;
      m_word_q = 0; m_dir = 3; m_drop = 0;

      // reset values
      step(32'd0, 0, 0, 0, 1);
      step(32'd0, 0, 0, 0, 1);
      chk("rst_dir", dir, 2'b11);
      chk("rst_q", q_count, 0);
      chk("rst_drop", drop_count, 0);
      step(32'd0, 0, 0, 0, 0);

      // UP accepted, then committed on tick
      step(C_UP, 0, 0, 0, 0);
      chk("up_q", q_count, 1);
      step(C_UP, 0, 1, 0, 0);
      chk("up_dir", dir, 2'b00);
      chk("up_chg", dir_changed, 1);
      chk("up_q0", q_count, 0);
      step(C_UP, 0, 0, 0, 0);
      chk("up_chg_off", dir_changed, 0);

      // reversal and redundant rejects against dir = RIGHT
      step(C_UP, 0, 0, 1, 0);
      step(C_LEFT, 0, 0, 0, 0);
      chk("rev_drop", drop_count, 1);
      chk("rev_q", q_count, 0);
      step(C_RIGHT, 0, 0, 0, 0);
      chk("red_drop", drop_count, 2);

      // two queued turns, drained by two ticks, then overflow
      step(C_UP, 0, 0, 0, 0);
      step(C_LEFT, 0, 0, 0, 0);
      chk("two_q", q_count, 2);
      step(C_LEFT, 0, 1, 0, 0);
      chk("tick1_dir", dir, 2'b00);
      step(C_LEFT, 0, 1, 0, 0);
      chk("tick2_dir", dir, 2'b10);
      step(C_DOWN, 0, 0, 0, 0);
      step(C_LEFT, 0, 0, 0, 0);
      step(C_UP, 0, 0, 0, 0);
      chk("full_drop", drop_count, 3);
      chk("full_q", q_count, 2);

      // push of DOWN while UP is being committed: rejected as reversal
      step(C_UP, 0, 0, 1, 0);
      step(C_RIGHT, 0, 0, 0, 0);
      step(C_UP, 0, 0, 0, 0);
      step(C_DOWN, 0, 1, 0, 0);
      chk("pp_dir", dir, 2'b00);
      chk("pp_q", q_count, 0);
      chk("pp_drop", drop_count, 5);

      // held ENTER gives one pulse; strobe gives another; same for MENU
      enter_seen = 0;
      for (int i = 0; i < 1000; i++) step(C_ENTER, 0, 0, 0, 0);
      chk("enter_once", enter_seen, 1);
      step(C_ENTER, 1, 0, 0, 0);
      step(C_ENTER, 0, 0, 0, 0);
      chk("enter_stb", enter_seen, 2);
      menu_seen = 0;
      for (int i = 0; i < 50; i++) step(C_MENU, 0, 0, 0, 0);
      step(C_MENU, 1, 0, 0, 0);
      step(C_MENU, 0, 0, 0, 0);
      chk("menu_cnt", menu_seen, 2);

      // restart beats tick with a full queue
      step(C_MENU, 0, 0, 1, 0);
      step(C_UP, 0, 0, 0, 0);
      step(C_LEFT, 0, 0, 0, 0);
      chk("rs_pre_q", q_count, 2);
      step(C_LEFT, 0, 1, 1, 0);
      chk("rs_q", q_count, 0);
      chk("rs_dir", dir, 2'b11);
      chk("rs_chg", dir_changed, 0);

      // reset mid-queue
      step(C_UP, 0, 0, 0, 0);
      step(C_UP, 0, 0, 0, 1);
      chk("mid_rst_q", q_count, 0);
      chk("mid_rst_drop", drop_count, 0);
      chk("mid_rst_dir", dir, 2'b11);
      step(C_UP, 0, 0, 0, 0);
      chk("rel_event_q", q_count, 1);

      // saturation of drop_count
      step(C_UP, 0, 0, 1, 0);
      for (int i = 0; i < 300; i++) step((i % 2) ? C_RIGHT : C_LEFT, 0, 0, 0, 0);
      chk("drop_sat", drop_count, 8'hFF);

      // randomized run
      rw = C_UP;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 35)
            rw = ($urandom_range(0, 9) == 0) ? $urandom : pool[$urandom_range(0, 7)];
         step(rw, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
